bf_power_ma: RTL and testbench

- Streaming beamformer power estimator: per accepted beat, computes y = sum over channels of conj(s_k)·x_k over N_CH antenna channels, then |y|^2.
- Smooths |y|^2 with a 2^LOG2_WIN-sample moving average.
- Sits after the ADC/IQ capture front end and feeds the direction-scan controller.
- Generalises the fixed 4-channel combinational abs-square complex-multiply: parametrised channel count, pipelined, backpressure, reloadable steering vector, built-in averager.

---
 rtl/bf_power_ma_if.sv | 38 +++
 rtl/bf_power_ma.sv | 153 +++++++++++++++
 tb/tb_bf_power_ma.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bf_power_ma_if.sv
`default_nettype none
// ============================================================================
// Module   : bf_power_ma_if
// Desc     : Sample/steering/result bundle for the beamformer power estimator.
// Revision : 1.0 - initial release
// ============================================================================
interface bf_power_ma_if #(
    parameter int WORD_LENGTH = 16,
    parameter int N_CH        = 4
);
    localparam int BEAM_W = 2*WORD_LENGTH + 1 + $clog2(N_CH);
    localparam int PWR_W  = 2*BEAM_W + 1;

    logic                        clear;
    logic                        s_load;
    logic [N_CH*WORD_LENGTH-1:0] s_i;
    logic [N_CH*WORD_LENGTH-1:0] s_q;
    logic                        in_valid;
    logic                        in_ready;
    logic [N_CH*WORD_LENGTH-1:0] x_i;
    logic [N_CH*WORD_LENGTH-1:0] x_q;
    logic                        out_valid;
    logic                        out_ready;
    logic [PWR_W-1:0]            out_power;
    logic [PWR_W-1:0]            out_avg;
    logic                        avg_full;

    modport master (
        output clear, s_load, s_i, s_q, in_valid, x_i, x_q, out_ready,
        input  in_ready, out_valid, out_power, out_avg, avg_full
    );

    modport slave (
        input  clear, s_load, s_i, s_q, in_valid, x_i, x_q, out_ready,
        output in_ready, out_valid, out_power, out_avg, avg_full
    );
endinterface
`default_nettype wire

// File: rtl/bf_power_ma.sv
`default_nettype none
// ============================================================================
// Module   : bf_power_ma
// Desc     : Pipelined beamformer |sum conj(s_k) x_k|^2 with moving average.
// Revision : 1.0 - initial release
// ============================================================================
module bf_power_ma #(
    parameter int WORD_LENGTH = 16,
    parameter int N_CH        = 4,
    parameter int LOG2_WIN    = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    bf_power_ma_if.slave bus
);
    localparam int W        = WORD_LENGTH;
    localparam int BEAM_W   = 2*W + 1 + $clog2(N_CH);
    localparam int PWR_W    = 2*BEAM_W + 1;
    localparam int C_PROD_W = 2*W + 1;
    localparam int C_SUM_W  = PWR_W + LOG2_WIN;
    localparam int C_WIN    = 1 << LOG2_WIN;
    localparam int C_FILL_W = LOG2_WIN + 1;

    logic [N_CH*W-1:0]           r_s_i, r_s_q;
    logic                        w_en;
    logic                        r_v1, r_v2, r_v3;
    logic signed [C_PROD_W-1:0]  w_pr [N_CH];
    logic signed [C_PROD_W-1:0]  w_pi [N_CH];
    logic signed [C_PROD_W-1:0]  r_pr [N_CH];
    logic signed [C_PROD_W-1:0]  r_pi [N_CH];
    logic signed [BEAM_W-1:0]    w_yre, w_yim, r_yre, r_yim;
    logic signed [PWR_W-1:0]     w_re_x, w_im_x, w_p, r_p;
    logic [PWR_W-1:0]            r_buf [C_WIN];
    logic [LOG2_WIN-1:0]         r_wptr;
    logic signed [C_SUM_W-1:0]   r_sum, w_sum_next;
    logic [C_FILL_W-1:0]         r_fill, w_fill_next;
    logic                        r_out_valid, r_full;
    logic [PWR_W-1:0]            r_out_power, r_out_avg;

    function automatic logic signed [C_PROD_W-1:0] sx(input logic [W-1:0] v);
        return {{(W+1){v[W-1]}}, v};
    endfunction

    function automatic logic signed [C_SUM_W-1:0] sxs(input logic [PWR_W-1:0] v);
        return {{LOG2_WIN{v[PWR_W-1]}}, v};
    endfunction

    assign w_en          = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = w_en & ~rst;
    assign bus.out_valid = r_out_valid;
    assign bus.out_power = r_out_power;
    assign bus.out_avg   = r_out_avg;
    assign bus.avg_full  = r_full;

    // Steering loads on its own strobe, independent of pipeline stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_i <= '0;
            r_s_q <= '0;
        end else if (bus.s_load && !bus.clear) begin
            r_s_i <= bus.s_i;
            r_s_q <= bus.s_q;
        end
    end

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            w_pr[k] = sx(r_s_i[k*W +: W]) * sx(bus.x_i[k*W +: W])
                    + sx(r_s_q[k*W +: W]) * sx(bus.x_q[k*W +: W]);
            w_pi[k] = sx(r_s_i[k*W +: W]) * sx(bus.x_q[k*W +: W])
                    - sx(r_s_q[k*W +: W]) * sx(bus.x_i[k*W +: W]);
        end
    end

    always_comb begin
        w_yre = '0;
        w_yim = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_yre = w_yre + {{(BEAM_W-C_PROD_W){r_pr[k][C_PROD_W-1]}}, r_pr[k]};
            w_yim = w_yim + {{(BEAM_W-C_PROD_W){r_pi[k][C_PROD_W-1]}}, r_pi[k]};
        end
    end

    assign w_re_x = {{(PWR_W-BEAM_W){r_yre[BEAM_W-1]}}, r_yre};
    assign w_im_x = {{(PWR_W-BEAM_W){r_yim[BEAM_W-1]}}, r_yim};
    assign w_p    = w_re_x * w_re_x + w_im_x * w_im_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_yre <= '0;
            r_yim <= '0;
            r_p   <= '0;
            for (int k = 0; k < N_CH; k++) begin
                r_pr[k] <= '0;
                r_pi[k] <= '0;
            end
        end else if (bus.clear) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_en) begin
            r_v1  <= bus.in_valid;
            r_v2  <= r_v1;
            r_v3  <= r_v2;
            r_yre <= w_yre;
            r_yim <= w_yim;
            r_p   <= w_p;
            for (int k = 0; k < N_CH; k++) begin
                r_pr[k] <= w_pr[k];
                r_pi[k] <= w_pi[k];
            end
        end
    end

    // Running window sum; the average is the arithmetic shift of the new sum.
    assign w_sum_next  = r_sum + sxs(r_p) - sxs(r_buf[r_wptr]);
    assign w_fill_next = (r_fill == C_FILL_W'(C_WIN)) ? r_fill : r_fill + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_power <= '0;
            r_out_avg   <= '0;
            r_full      <= 1'b0;
            r_sum       <= '0;
            r_wptr      <= '0;
            r_fill      <= '0;
            for (int i = 0; i < C_WIN; i++) r_buf[i] <= '0;
        end else if (bus.clear) begin
            r_out_valid <= 1'b0;
            r_full      <= 1'b0;
            r_sum       <= '0;
            r_wptr      <= '0;
            r_fill      <= '0;
            for (int i = 0; i < C_WIN; i++) r_buf[i] <= '0;
        end else if (w_en) begin
            r_out_valid <= r_v3;
            if (r_v3) begin
                r_buf[r_wptr] <= r_p;
                r_sum         <= w_sum_next;
                r_wptr        <= r_wptr + 1'b1;
                r_fill        <= w_fill_next;
                r_full        <= (w_fill_next == C_FILL_W'(C_WIN));
                r_out_power   <= r_p;
                r_out_avg     <= w_sum_next[LOG2_WIN +: PWR_W];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bf_power_ma.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf_power_ma
// Desc     : Randomised + directed bench for bf_power_ma against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bf_power_ma;
    localparam int W   = 16;
    localparam int N   = 4;
    localparam int LW  = 4;
    localparam int WIN = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bf_power_ma_if #(.WORD_LENGTH(W), .N_CH(N)) bus ();

    bf_power_ma #(.WORD_LENGTH(W), .N_CH(N), .LOG2_WIN(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks, failures, cyc, first_acc, first_out, m_cnt;
    logic [N*W-1:0] m_si, m_sq;
    logic [127:0]   exp_pw[$], exp_av[$], win[$];
    bit             exp_fl[$];
    bit             prev_clear, prev_stall;
    logic [127:0]   hold_p, hold_a;
    logic           hold_f;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] rep(input logic [W-1:0] v);
        return {N{v}};
    endfunction

    // |sum_k conj(s_k) * x_k|^2 in wide integer arithmetic.
    function automatic logic [127:0] pwr(input logic [N*W-1:0] si, sq, xi, xq);
        logic signed [127:0] re, im, a, b, c, d;
        re = 0;
        im = 0;
        for (int k = 0; k < N; k++) begin
            a = $signed(si[k*W +: W]);
            b = $signed(sq[k*W +: W]);
            c = $signed(xi[k*W +: W]);
            d = $signed(xq[k*W +: W]);
            re = re + a*c + b*d;
            im = im + a*d - b*c;
        end
        return re*re + im*im;
    endfunction

    task automatic model_flush();
        exp_pw.delete();
        exp_av.delete();
        exp_fl.delete();
        win.delete();
        m_cnt = 0;
    endtask

    task automatic step();
        logic         acc;
        logic [127:0] p, s;
        #1;
        acc = bus.in_valid && bus.in_ready && !bus.clear;
        chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
        if (prev_clear) begin
            chk("clr_valid", bus.out_valid, 0);
            chk("clr_full", bus.avg_full, 0);
        end
        if (prev_stall) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_power", bus.out_power, hold_p);
            chk("hold_avg", bus.out_avg, hold_a);
            chk("hold_full", bus.avg_full, hold_f);
        end
        if (bus.out_valid && bus.out_ready) begin
            if (first_out < 0) first_out = cyc;
            chk("out_pending", exp_pw.size() > 0, 1);
            if (exp_pw.size() > 0) begin
                chk("out_power", bus.out_power, exp_pw.pop_front());
                chk("out_avg", bus.out_avg, exp_av.pop_front());
                chk("avg_full", bus.avg_full, exp_fl.pop_front());
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready && !bus.clear;
        hold_p     = bus.out_power;
        hold_a     = bus.out_avg;
        hold_f     = bus.avg_full;
        prev_clear = bus.clear;
        if (acc && first_acc < 0) first_acc = cyc;
        @(posedge clk);
        if (bus.clear) begin
            model_flush();
        end else begin
            if (acc) begin
                p = pwr(m_si, m_sq, bus.x_i, bus.x_q);
                win.push_back(p);
                if (win.size() > WIN) void'(win.pop_front());
                m_cnt++;
                s = 0;
                foreach (win[i]) s = s + win[i];
                exp_pw.push_back(p);
                exp_av.push_back(s >> LW);
                exp_fl.push_back(m_cnt >= WIN);
            end
            if (bus.s_load) begin
                m_si = bus.s_i;
                m_sq = bus.s_q;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic load_steer(input logic [W-1:0] re, input logic [W-1:0] im);
        bus.s_load = 1'b1;
        bus.s_i    = rep(re);
        bus.s_q    = rep(im);
        step();
        bus.s_load = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    task automatic beats(input int n, input logic [W-1:0] xr, input logic [W-1:0] xm);
        bus.in_valid = 1'b1;
        bus.x_i      = rep(xr);
        bus.x_q      = rep(xm);
        repeat (n) step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12 && exp_pw.size() > 0; i++) step();
        chk("drain_empty", exp_pw.size(), 0);
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; first_acc = -1; first_out = -1;
        prev_clear = 0; prev_stall = 0; m_si = '0; m_sq = '0;
        model_flush();
        rst = 1'b1;
        bus.clear = 1'b0; bus.s_load = 1'b0; bus.s_i = '0; bus.s_q = '0;
        bus.in_valid = 1'b0; bus.x_i = '0; bus.x_q = '0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_power", bus.out_power, 0);
        chk("rst_avg", bus.out_avg, 0);
        chk("rst_full", bus.avg_full, 0);
        @(negedge clk);
        rst = 1'b0;

        // Steering (1,0), x=(100,0): steady 160000 with ramping average.
        load_steer(16'd1, 16'd0);
        first_acc = -1; first_out = -1;
        beats(20, 16'd100, 16'd0);
        drain();
        chk("latency", first_out - first_acc, 4);

        // Rotated steering cases.
        do_clear();
        load_steer(16'd0, 16'd1);
        beats(1, 16'd0, 16'd100);
        beats(1, 16'd100, 16'd0);
        drain();

        // Full-scale negative extremes.
        do_clear();
        load_steer(16'h8000, 16'h8000);
        beats(3, 16'h8000, 16'h8000);
        drain();

        // Window wrap down to zero.
        do_clear();
        load_steer(16'd1, 16'd0);
        beats(16, 16'd100, 16'd0);
        beats(16, 16'd0, 16'd0);
        drain();

        // Backpressure mid-stream.
        bus.in_valid = 1'b1; bus.x_i = rep(16'd100); bus.x_q = rep(16'd50);
        repeat (8) step();
        bus.out_ready = 1'b0;
        repeat (5) step();
        bus.out_ready = 1'b1;
        repeat (8) step();
        drain();

        // s_load coincident with an accepted beat, then clear mid-window.
        bus.in_valid = 1'b1; bus.x_i = rep(16'd100); bus.x_q = rep(16'd50);
        bus.s_load = 1'b1; bus.s_i = rep(16'd1); bus.s_q = rep(16'd1);
        step();
        bus.s_load = 1'b0;
        repeat (5) step();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        repeat (6) step();
        drain();

        // Randomised traffic with stalls, reloads and occasional clears.
        for (int n = 0; n < 500; n++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.out_ready = ($urandom % 4) != 0;
            bus.x_i       = {$urandom, $urandom};
            bus.x_q       = {$urandom, $urandom};
            bus.s_load    = ($urandom % 16) == 0;
            bus.s_i       = {$urandom, $urandom};
            bus.s_q       = {$urandom, $urandom};
            bus.clear     = ($urandom % 60) == 0;
            step();
        end
        bus.s_load = 1'b0; bus.clear = 1'b0;
        drain();

        // Asynchronous reset mid-stream clears steering as well.
        bus.in_valid = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        chk("arst_power", bus.out_power, 0);
        @(negedge clk);
        rst = 1'b0;
        model_flush();
        m_si = '0; m_sq = '0; prev_stall = 0; prev_clear = 0;
        beats(2, 16'd100, 16'd100);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
